// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the register-bus transfer controller:
// the state encoding, the immediate-source selector and a one-hot decoder.
package bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_LATCH,
        ST_RELEASE,
        ST_FAULT
    } state_t;

    // Widest selector the shared decoder handles; it covers up to 256 registers.
    localparam int MAX_SEL_WIDTH = 8;
    localparam int MAX_REGS      = 1 << MAX_SEL_WIDTH;

    // The selector value just past the last register means "drive the immediate".
    function automatic int imm_select(input int num_regs);
        return num_regs;
    endfunction

    function automatic logic [MAX_REGS-1:0] onehot(input logic [MAX_SEL_WIDTH-1:0] sel,
                                                   input logic                     en);
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Enabled selector-to-one-hot decoder; selectors at or beyond num_regs give all zeros.
module onehot_decode
    import bus_ctrl_pkg::*;
#(
    parameter int sel_width = 3,
    parameter int num_regs  = 4
) (
    input  logic [sel_width-1:0] sel,
    input  logic                 en,
    output logic [num_regs-1:0]  onehot_out
);

    assign onehot_out = num_regs'(onehot(MAX_SEL_WIDTH'(sel), en));

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Initiator for the shared register bus: each accepted request moves one word
// from a register (or an immediate it drives itself) into a destination register.
module bus_transfer_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int data_bus_size = 4,
    parameter int num_regs      = 4,
    parameter int sel_width     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [sel_width-1:0]     req_src,
    input  logic [sel_width-1:0]     req_dst,
    input  logic [data_bus_size-1:0] req_imm,
    output logic [num_regs-1:0]      oe,
    output logic [num_regs-1:0]      latch,
    inout  wire  [data_bus_size-1:0] data_bus,
    output logic [data_bus_size-1:0] bus_capture,
    output logic                     done,
    output logic                     err
);

    localparam logic [sel_width-1:0] IMM_SEL = sel_width'(imm_select(num_regs));

    state_t                   state_q, state_d;
    logic [sel_width-1:0]     src_q, src_d;
    logic [sel_width-1:0]     dst_q, dst_d;
    logic [data_bus_size-1:0] imm_q, imm_d;
    logic [data_bus_size-1:0] capture_q, capture_d;
    logic [num_regs-1:0]      oe_q, oe_d;
    logic [num_regs-1:0]      latch_q, latch_d;
    logic                     drive_q, drive_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     ready_q, ready_d;
    logic                     req_ok;
    logic                     source_phase;
    logic                     oe_en;
    logic                     latch_en;

    // IMM_SEL equals num_regs, so it doubles as the bound for both selectors.
    always_comb begin
        req_ok = (req_src <= IMM_SEL) && (req_dst < IMM_SEL) && (req_src != req_dst);
    end

    // Strobes are computed from the next state so every output is a flop
    // that lines up with the state it belongs to.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        capture_d = capture_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    src_d   = req_src;
                    dst_d   = req_dst;
                    imm_d   = req_imm;
                    state_d = req_ok ? ST_DRIVE : ST_FAULT;
                end
            end
            ST_DRIVE:   state_d = ST_LATCH;
            ST_LATCH: begin
                capture_d = data_bus;
                state_d   = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            ST_FAULT:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        source_phase = (state_d == ST_DRIVE) || (state_d == ST_LATCH);
        oe_en        = source_phase && (src_d != IMM_SEL);
        drive_d      = source_phase && (src_d == IMM_SEL);
        latch_en     = (state_d == ST_LATCH);
        done_d       = (state_d == ST_RELEASE) || (state_d == ST_FAULT);
        err_d        = (state_d == ST_FAULT);
        ready_d      = (state_d == ST_IDLE);
    end

    onehot_decode #(
        .sel_width (sel_width),
        .num_regs  (num_regs)
    ) u_oe_dec (
        .sel        (src_d),
        .en         (oe_en),
        .onehot_out (oe_d)
    );

    onehot_decode #(
        .sel_width (sel_width),
        .num_regs  (num_regs)
    ) u_latch_dec (
        .sel        (dst_d),
        .en         (latch_en),
        .onehot_out (latch_d)
    );

    // Asynchronous reset drops every strobe and releases the bus at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            imm_q     <= '0;
            capture_q <= '0;
            oe_q      <= '0;
            latch_q   <= '0;
            drive_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            imm_q     <= imm_d;
            capture_q <= capture_d;
            oe_q      <= oe_d;
            latch_q   <= latch_d;
            drive_q   <= drive_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    assign data_bus    = drive_q ? imm_q : 'z;
    assign oe          = oe_q;
    assign latch       = latch_q;
    assign bus_capture = capture_q;
    assign done        = done_q;
    assign err         = err_q;
    assign req_ready   = ready_q;

endmodule
